div_iter: RTL and testbench

- Iterative radix-2 restoring integer divider: the inverse-direction companion to the pipelined multiplier in the execute stage.
- Accepts one RV32M divide/remainder op (DIV, DIVU, REM, REMU) and resolves one quotient bit per cycle.
- Returns a single XLEN-bit result with a one-cycle done pulse.
- Not pipelined: one op in flight; the issue logic must check ready.

---
 rtl/sys_defs.sv | 17 +
 rtl/div_iter_stage.sv | 29 ++
 rtl/div_iter.sv | 154 +++++++++++++++
 tb/tb_div_iter.sv | 227 ++++++++++++++++++++++
 4 files changed

// File: rtl/sys_defs.sv
// Shared execute-stage definitions for the iterative divider.
//   XLEN        : integer operand/result width
//   DIV_LATENCY : CALC cycles for a non-special divide (issue scheduler uses it)
//   div_func_t  : RV32M divide/remainder function encoding
package sys_defs;

  localparam int unsigned XLEN        = 32;
  localparam int unsigned DIV_LATENCY = XLEN;

  typedef enum logic [1:0] {
    DIV  = 2'b00,
    DIVU = 2'b01,
    REM  = 2'b10,
    REMU = 2'b11
  } div_func_t;

endpackage

// File: rtl/div_iter_stage.sv
// One combinational radix-2 restoring division step.
//   rem_in       : partial remainder (XLEN+1 bits)
//   divisor      : unsigned divisor magnitude
//   dividend_bit : next dividend bit shifted into the remainder
//   rem_out      : next partial remainder
//   quo_bit      : quotient bit produced by this step
module div_stage #(
  parameter int unsigned XLEN = 32
) (
  input  logic [XLEN:0]   rem_in,
  input  logic [XLEN-1:0] divisor,
  input  logic            dividend_bit,
  output logic [XLEN:0]   rem_out,
  output logic            quo_bit
);

  logic [XLEN:0]   shifted;
  logic [XLEN+1:0] diff;

  // A set rem_in MSB means the true shifted value exceeds 2^(XLEN+1), so
  // the subtraction must succeed; the low XLEN+1 bits of diff are still exact.
  always_comb begin
    shifted = {rem_in[XLEN-1:0], dividend_bit};
    diff    = {1'b0, shifted} - {2'b00, divisor};
    quo_bit = rem_in[XLEN] | ~diff[XLEN+1];
    rem_out = quo_bit ? diff[XLEN:0] : shifted;
  end

endmodule

// File: rtl/div_iter.sv
// Iterative radix-2 restoring divider for RV32M DIV/DIVU/REM/REMU.
// One op in flight; one quotient bit per cycle; single-cycle done pulse.
//   clock, reset (sync, active-low)
//   start/func/dividend/divisor/tag_in : request, accepted when ready=1
//   flush    : abort any op, no done
//   ready    : high in IDLE or DONE
//   result   : quotient or remainder, held until next completion
//   tag_out  : tag of completing op
//   done     : one-cycle completion pulse
module div_iter #(
  parameter int unsigned XLEN  = 32,
  parameter int unsigned TAG_W = 6
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             start,
  input  logic [1:0]       func,
  input  logic [XLEN-1:0]  dividend,
  input  logic [XLEN-1:0]  divisor,
  input  logic [TAG_W-1:0] tag_in,
  input  logic             flush,
  output logic             ready,
  output logic [XLEN-1:0]  result,
  output logic [TAG_W-1:0] tag_out,
  output logic             done
);

  import sys_defs::*;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_CALC = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  localparam int unsigned     CNT_W   = $clog2(XLEN);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(XLEN - 1);
  localparam logic [XLEN-1:0] MIN_NEG = {1'b1, {(XLEN-1){1'b0}}};

  logic [1:0]       state;
  logic [CNT_W-1:0] count;
  logic [XLEN:0]    rem_q;
  logic [XLEN-1:0]  quo_q;     // dividend bits shift out the top, quotient in the bottom
  logic [XLEN-1:0]  divisor_q;
  logic             quo_neg_q;
  logic             rem_neg_q;
  div_func_t        func_q;
  logic [TAG_W-1:0] tag_q;

  // accept-time decode
  div_func_t       func_in;
  logic            is_signed;
  logic            a_neg;
  logic            b_neg;
  logic [XLEN-1:0] a_abs;
  logic [XLEN-1:0] b_abs;
  logic            div_zero;
  logic            overflow;
  logic [XLEN-1:0] special_res;

  // iteration / completion
  logic [XLEN:0]   rem_nx;
  logic            quo_bit;
  logic [XLEN-1:0] quo_nx;
  logic [XLEN-1:0] quo_fix;
  logic [XLEN-1:0] rem_fix;

  assign ready = (state == S_IDLE) || (state == S_DONE);

  always_comb begin
    func_in     = div_func_t'(func);
    is_signed   = (func_in == DIV) || (func_in == REM);
    a_neg       = is_signed & dividend[XLEN-1];
    b_neg       = is_signed & divisor[XLEN-1];
    a_abs       = a_neg ? (~dividend + 1'b1) : dividend;
    b_abs       = b_neg ? (~divisor + 1'b1) : divisor;
    div_zero    = (divisor == '0);
    overflow    = is_signed && (dividend == MIN_NEG) && (divisor == '1);
    special_res = '0;
    if (div_zero)
      special_res = func[1] ? dividend : '1;
    else
      special_res = func[1] ? '0 : MIN_NEG;
  end

  div_stage #(.XLEN(XLEN)) u_stage (
    .rem_in       (rem_q),
    .divisor      (divisor_q),
    .dividend_bit (quo_q[XLEN-1]),
    .rem_out      (rem_nx),
    .quo_bit      (quo_bit)
  );

  always_comb begin
    quo_nx  = {quo_q[XLEN-2:0], quo_bit};
    quo_fix = quo_neg_q ? (~quo_nx + 1'b1) : quo_nx;
    rem_fix = rem_neg_q ? (~rem_nx[XLEN-1:0] + 1'b1) : rem_nx[XLEN-1:0];
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      state     <= S_IDLE;
      count     <= '0;
      rem_q     <= '0;
      quo_q     <= '0;
      divisor_q <= '0;
      quo_neg_q <= 1'b0;
      rem_neg_q <= 1'b0;
      func_q    <= DIV;
      tag_q     <= '0;
      result    <= '0;
      tag_out   <= '0;
      done      <= 1'b0;
    end else if (flush) begin
      state <= S_IDLE;
      done  <= 1'b0;
    end else begin
      case (state)
        S_CALC: begin
          rem_q <= rem_nx;
          quo_q <= quo_nx;
          count <= count + CNT_W'(1);
          if (count == CNT_LAST) begin
            result  <= ((func_q == REM) || (func_q == REMU)) ? rem_fix : quo_fix;
            tag_out <= tag_q;
            done    <= 1'b1;
            state   <= S_DONE;
          end
        end
        default: begin // S_IDLE, S_DONE
          done  <= 1'b0;
          state <= S_IDLE;
          if (start) begin
            func_q    <= func_in;
            tag_q     <= tag_in;
            divisor_q <= b_abs;
            quo_q     <= a_abs;
            rem_q     <= '0;
            count     <= '0;
            quo_neg_q <= a_neg ^ b_neg;
            rem_neg_q <= a_neg;
            if (div_zero || overflow) begin
              result  <= special_res;
              tag_out <= tag_in;
              done    <= 1'b1;
              state   <= S_DONE;
            end else begin
              state <= S_CALC;
            end
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_div_iter.sv
module tb_div_iter;

  localparam logic [1:0] F_DIV  = 2'b00;
  localparam logic [1:0] F_DIVU = 2'b01;
  localparam logic [1:0] F_REM  = 2'b10;
  localparam logic [1:0] F_REMU = 2'b11;
  localparam int NVEC   = 17;
  localparam int NRAND  = 1000;
  localparam int TMO    = 100;

  logic        clock;
  logic        reset;
  logic        start;
  logic [1:0]  func;
  logic [31:0] dividend;
  logic [31:0] divisor;
  logic [5:0]  tag_in;
  logic        flush;
  logic        ready;
  logic [31:0] result;
  logic [5:0]  tag_out;
  logic        done;

  int total = 0;
  int bad   = 0;

  div_iter #(.XLEN(32), .TAG_W(6)) dut (
    .clock    (clock),
    .reset    (reset),
    .start    (start),
    .func     (func),
    .dividend (dividend),
    .divisor  (divisor),
    .tag_in   (tag_in),
    .flush    (flush),
    .ready    (ready),
    .result   (result),
    .tag_out  (tag_out),
    .done     (done)
  );

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  typedef struct {
    logic [1:0]  f;
    logic [31:0] a;
    logic [31:0] b;
    logic [5:0]  t;
    logic [31:0] r;
    int          lat;
  } vec_t;

  vec_t vecs [NVEC];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic tick;
    @(posedge clock);
    #1;
  endtask

  // edges after the accept edge until done is seen (TMO on timeout)
  task automatic wait_done(output int edges);
    edges = 0;
    while (!done && edges < TMO) begin
      tick();
      edges++;
    end
  endtask

  task automatic do_op(input logic [1:0] f, input logic [31:0] a, input logic [31:0] b,
                       input logic [5:0] t, output int edges);
    start = 1'b1; func = f; dividend = a; divisor = b; tag_in = t;
    tick();
    start = 1'b0;
    wait_done(edges);
  endtask

  function automatic logic [31:0] ref_div(input logic [1:0] f, input logic [31:0] a,
                                          input logic [31:0] b);
    if (b == 32'd0)
      return f[1] ? a : 32'hFFFF_FFFF;
    if (!f[0]) begin
      if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF)
        return f[1] ? 32'd0 : 32'h8000_0000;
      return f[1] ? 32'($signed(a) % $signed(b)) : 32'($signed(a) / $signed(b));
    end
    return f[1] ? (a % b) : (a / b);
  endfunction

  initial begin
    int edges;
    int edges2;
    int seen;
    logic [1:0]  rf;
    logic [31:0] ra;
    logic [31:0] rb;
    logic [5:0]  rt;
    int          sel;
    int          rlat;

    vecs[0]  = '{F_DIVU, 32'd100,        32'd7,          6'd5,  32'd14,         32};
    vecs[1]  = '{F_REMU, 32'd100,        32'd7,          6'd6,  32'd2,          32};
    vecs[2]  = '{F_DIV,  32'hFFFF_FFF9,  32'd2,          6'd7,  32'hFFFF_FFFD,  32};
    vecs[3]  = '{F_REM,  32'hFFFF_FFF9,  32'd2,          6'd8,  32'hFFFF_FFFF,  32};
    vecs[4]  = '{F_REM,  32'd7,          32'hFFFF_FFFE,  6'd9,  32'd1,          32};
    vecs[5]  = '{F_DIV,  32'h8000_0000,  32'hFFFF_FFFF,  6'd10, 32'h8000_0000,  0};
    vecs[6]  = '{F_REM,  32'h8000_0000,  32'hFFFF_FFFF,  6'd11, 32'd0,          0};
    vecs[7]  = '{F_DIVU, 32'd5,          32'd0,          6'd12, 32'hFFFF_FFFF,  0};
    vecs[8]  = '{F_REMU, 32'd5,          32'd0,          6'd13, 32'd5,          0};
    vecs[9]  = '{F_DIV,  32'd5,          32'd0,          6'd14, 32'hFFFF_FFFF,  0};
    vecs[10] = '{F_REM,  32'hFFFF_FFFB,  32'd0,          6'd15, 32'hFFFF_FFFB,  0};
    vecs[11] = '{F_DIVU, 32'hFFFF_FFFF,  32'd1,          6'd16, 32'hFFFF_FFFF,  32};
    vecs[12] = '{F_DIVU, 32'h8000_0000,  32'hFFFF_FFFF,  6'd17, 32'd0,          32};
    vecs[13] = '{F_REMU, 32'h8000_0000,  32'hFFFF_FFFF,  6'd18, 32'h8000_0000,  32};
    vecs[14] = '{F_DIV,  32'hFFFF_FF9C,  32'hFFFF_FFF9,  6'd19, 32'd14,         32};
    vecs[15] = '{F_REM,  32'hFFFF_FF9C,  32'hFFFF_FFF9,  6'd20, 32'hFFFF_FFFE,  32};
    vecs[16] = '{F_DIV,  32'h8000_0000,  32'd2,          6'd63, 32'hC000_0000,  32};

    reset = 1'b0; start = 1'b0; flush = 1'b0; func = F_DIV;
    dividend = '0; divisor = '0; tag_in = '0;
    repeat (3) tick();
    check("reset_done",   32'(done),    32'd0);
    check("reset_ready",  32'(ready),   32'd1);
    check("reset_result", result,       32'd0);
    check("reset_tag",    32'(tag_out), 32'd0);
    reset = 1'b1;
    tick();

    for (int i = 0; i < NVEC; i++) begin
      check($sformatf("v%0d_ready", i), 32'(ready), 32'd1);
      do_op(vecs[i].f, vecs[i].a, vecs[i].b, vecs[i].t, edges);
      check($sformatf("v%0d_latency", i), 32'(edges),   32'(vecs[i].lat));
      check($sformatf("v%0d_result", i),  result,       vecs[i].r);
      check($sformatf("v%0d_tag", i),     32'(tag_out), 32'(vecs[i].t));
      tick();
      check($sformatf("v%0d_done_fall", i), 32'(done), 32'd0);
    end

    // back-to-back: start held through CALC (ignored) and DONE (accepted)
    start = 1'b1; func = F_DIVU; dividend = 32'd100; divisor = 32'd7; tag_in = 6'd1;
    tick();
    func = F_REMU; tag_in = 6'd2;
    wait_done(edges);
    check("b2b_first_latency", 32'(edges),   32'd32);
    check("b2b_first_result",  result,       32'd14);
    check("b2b_first_tag",     32'(tag_out), 32'd1);
    tick();
    start = 1'b0;
    check("b2b_gap_done",  32'(done),  32'd0);
    check("b2b_gap_ready", 32'(ready), 32'd0);
    wait_done(edges2);
    check("b2b_second_latency", 32'(edges2),  32'd32);
    check("b2b_second_result",  result,       32'd2);
    check("b2b_second_tag",     32'(tag_out), 32'd2);
    tick();

    // flush at CALC cycle 10 with a concurrent (special-case) start
    start = 1'b1; func = F_DIVU; dividend = 32'd100; divisor = 32'd7; tag_in = 6'd3;
    tick();
    start = 1'b0;
    repeat (9) tick();
    flush = 1'b1; start = 1'b1; func = F_DIVU; dividend = 32'd5; divisor = 32'd0; tag_in = 6'd4;
    tick();
    flush = 1'b0; start = 1'b0;
    check("flush_ready", 32'(ready), 32'd1);
    check("flush_done",  32'(done),  32'd0);
    seen = 0;
    for (int i = 0; i < 40; i++) begin
      tick();
      if (done) seen++;
    end
    check("flush_no_done_40", 32'(seen),    32'd0);
    check("flush_result_kept", result,      32'd2);
    check("flush_tag_kept",   32'(tag_out), 32'd2);

    // reset in the middle of CALC
    start = 1'b1; func = F_DIVU; dividend = 32'd1000; divisor = 32'd3; tag_in = 6'd9;
    tick();
    start = 1'b0;
    repeat (5) tick();
    reset = 1'b0;
    tick();
    check("midreset_done",   32'(done),    32'd0);
    check("midreset_ready",  32'(ready),   32'd1);
    check("midreset_result", result,       32'd0);
    check("midreset_tag",    32'(tag_out), 32'd0);
    reset = 1'b1;
    tick();

    // random sweep against a behavioural reference
    for (int n = 0; n < NRAND; n++) begin
      rf  = 2'($urandom_range(0, 3));
      ra  = $urandom;
      rb  = $urandom;
      rt  = 6'($urandom);
      sel = $urandom_range(0, 7);
      case (sel)
        0: rb = 32'd0;
        1: begin ra = 32'h8000_0000; rb = 32'hFFFF_FFFF; end
        2: rb = 32'($urandom_range(1, 15));
        3: ra = 32'($urandom_range(0, 15));
        4: rb = 32'hFFFF_FFFF - 32'($urandom_range(0, 3));
        default: ;
      endcase
      rlat = (rb == 32'd0 || (!rf[0] && ra == 32'h8000_0000 && rb == 32'hFFFF_FFFF)) ? 0 : 32;
      do_op(rf, ra, rb, rt, edges);
      check($sformatf("rand%0d_f%0d_%h_%h_result", n, rf, ra, rb), result, ref_div(rf, ra, rb));
      check($sformatf("rand%0d_latency", n), 32'(edges),   32'(rlat));
      check($sformatf("rand%0d_tag", n),     32'(tag_out), 32'(rt));
      tick();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
